// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial N-bit subtractor (a - b mod 2^N, borrow) with
//            start/busy/done handshake, LSB first through one full-subtractor.
// Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         busy,
  output logic         done
);

  localparam int              CW     = (N > 1) ? $clog2(N + 1) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(N - 1);
  localparam logic [CW-1:0]   C_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic [N-1:0]  a_q,      a_d;
  logic [N-1:0]  b_q,      b_d;
  logic [N-1:0]  dsr_q,    dsr_d;
  logic          br_q,     br_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [N-1:0]  diff_q,   diff_d;
  logic          borrow_q, borrow_d;

  logic          cell_x, cell_y, cell_d, cell_bout;
  logic [N-1:0]  dsr_next, a_shift, b_shift;

  assign cell_x    = a_q[0];
  assign cell_y    = b_q[0];
  assign cell_d    = cell_x ^ cell_y ^ br_q;
  assign cell_bout = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & br_q);

  // A one-bit datapath has nothing to shift down, so it is handled apart.
  generate
    if (N == 1) begin : g_narrow
      assign dsr_next = cell_d;
      assign a_shift  = 1'b0;
      assign b_shift  = 1'b0;
    end else begin : g_wide
      assign dsr_next = {cell_d, dsr_q[N-1:1]};
      assign a_shift  = {1'b0, a_q[N-1:1]};
      assign b_shift  = {1'b0, b_q[N-1:1]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    dsr_d    = dsr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = 1'b0;
          dsr_d   = '0;
          cnt_d   = '0;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        dsr_d = dsr_next;
        br_d  = cell_bout;
        a_d   = a_shift;
        b_d   = b_shift;
        cnt_d = cnt_q + C_ONE;
        // Result registers are only written here, so they never show partials.
        if (cnt_q == C_LAST) begin
          state_d  = S_DONE;
          diff_d   = dsr_next;
          borrow_d = cell_bout;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      dsr_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dsr_q    <= dsr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// Testbench for serial_subtractor: N=4, N=8 and N=1 instances against an
// arithmetic reference (a - b mod 2^N, borrow = a < b).
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       s4, s8, s1;
  logic [3:0] a4, b4, d4;
  logic [7:0] a8, b8, d8;
  logic [0:0] a1, b1, d1;
  logic       br4, br8, br1, busy4, busy8, busy1, done4, done8, done1;

  serial_subtractor #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4),
    .diff(d4), .borrow(br4), .busy(busy4), .done(done4));
  serial_subtractor #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
    .diff(d8), .borrow(br8), .busy(busy8), .done(done8));
  serial_subtractor #(.N(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1),
    .diff(d1), .borrow(br1), .busy(busy1), .done(done1));

  int checks = 0;
  int errors = 0;

  int         sel = 4;
  logic [7:0] cur_diff;
  logic       cur_borrow, cur_busy, cur_done;

  always_comb begin
    cur_diff   = 8'h00;
    cur_borrow = 1'b0;
    cur_busy   = 1'b0;
    cur_done   = 1'b0;
    case (sel)
      8: begin cur_diff = d8; cur_borrow = br8; cur_busy = busy8; cur_done = done8; end
      1: begin cur_diff = {7'd0, d1}; cur_borrow = br1; cur_busy = busy1; cur_done = done1; end
      default: begin cur_diff = {4'd0, d4}; cur_borrow = br4; cur_busy = busy4; cur_done = done4; end
    endcase
  end

  task automatic drive(input int w, input logic [7:0] av, input logic [7:0] bv, input logic st);
    case (w)
      8: begin a8 = av; b8 = bv; s8 = st; end
      1: begin a1 = av[0:0]; b1 = bv[0:0]; s1 = st; end
      default: begin a4 = av[3:0]; b4 = bv[3:0]; s4 = st; end
    endcase
  endtask

  // Issue one start pulse and observe w+4 cycles after the accepting edge.
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        output int first, output int ndone, output int nbusy,
                        output logic [7:0] dv, output logic bo, output int partial);
    logic [7:0] prev;
    first = 0; ndone = 0; nbusy = 0; partial = 0; dv = 8'h00; bo = 1'b0;
    @(negedge clk);
    sel  = w;
    #0;
    prev = cur_diff;
    drive(w, av, bv, 1'b1);
    for (int idx = 1; idx <= w + 4; idx++) begin
      @(negedge clk);
      if (idx == 1) drive(w, ~av, ~bv, 1'b0);
      if (cur_busy) nbusy++;
      if (cur_done) begin
        if (first == 0) begin
          first = idx;
          dv    = cur_diff;
          bo    = cur_borrow;
        end
        ndone++;
      end
      if (first == 0 && cur_diff !== prev) partial++;
    end
  endtask

  // Reference model plus all per-operation comparisons.
  task automatic check_op(input int w, input logic [7:0] av, input logic [7:0] bv, input string tag);
    int first, ndone, nbusy, partial, mask, ed;
    logic [7:0] dv;
    logic bo, eb;
    mask = (1 << w) - 1;
    ed   = (int'(av & 8'(mask)) - int'(bv & 8'(mask))) & mask;
    eb   = ((av & 8'(mask)) < (bv & 8'(mask)));
    run_op(w, av, bv, first, ndone, nbusy, dv, bo, partial);
    checks++;
    if (first !== w + 1) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", tag, first, w + 1);
    end
    checks++;
    if (ndone !== 1) begin
      errors++; $display("FAIL %s done_count: got %0d expected 1", tag, ndone);
    end
    checks++;
    if (nbusy !== w + 1) begin
      errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, nbusy, w + 1);
    end
    checks++;
    if (dv !== 8'(ed)) begin
      errors++; $display("FAIL %s diff (a=%0d b=%0d): got %0d expected %0d", tag, av, bv, dv, ed);
    end
    checks++;
    if (bo !== eb) begin
      errors++; $display("FAIL %s borrow (a=%0d b=%0d): got %0b expected %0b", tag, av, bv, bo, eb);
    end
    checks++;
    if (partial !== 0) begin
      errors++; $display("FAIL %s diff_changed_early: got %0d changes expected 0", tag, partial);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4, 8'h0, 8'h0, 1'b0);
    drive(8, 8'h0, 8'h0, 1'b0);
    drive(1, 8'h0, 8'h0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if ({d4, br4, busy4, done4} !== 7'd0) begin
      errors++; $display("FAIL reset_n4: got %b expected 0000000", {d4, br4, busy4, done4});
    end
    checks++;
    if ({d8, br8, busy8, done8} !== 11'd0 || {d1, br1, busy1, done1} !== 4'd0) begin
      errors++; $display("FAIL reset_n8_n1: got %b/%b expected zeros", {d8, br8, busy8, done8}, {d1, br1, busy1, done1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    check_op(4, 8'd9, 8'd3,  "n4_9m3");
    check_op(4, 8'd3, 8'd9,  "n4_3m9");
    check_op(4, 8'd0, 8'd15, "n4_0m15");
    check_op(4, 8'd5, 8'd5,  "n4_5m5");
  endtask

  task automatic test_ignore_start();
    int ndone;
    logic [3:0] dv;
    ndone = 0; dv = 4'h0;
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd3; s4 = 1'b1;
    for (int idx = 1; idx <= 9; idx++) begin
      @(negedge clk);
      if (done4) begin ndone++; dv = d4; end
      s4 = (idx == 2 || idx == 5);
      a4 = (idx == 2) ? 4'd1 : 4'd15;
      b4 = (idx == 2) ? 4'd2 : 4'd0;
    end
    checks++;
    if (ndone !== 1) begin
      errors++; $display("FAIL ignore_start done_count: got %0d expected 1", ndone);
    end
    checks++;
    if (dv !== 4'd6 || d4 !== 4'd6 || busy4 !== 1'b0) begin
      errors++; $display("FAIL ignore_start result: got diff %0d/%0d busy %0b expected 6/6 busy 0", dv, d4, busy4);
    end
  endtask

  task automatic test_back_to_back();
    int dones[$];
    int bad;
    bad = 0;
    @(negedge clk);
    a4 = 4'd12; b4 = 4'd4; s4 = 1'b1;
    for (int idx = 1; idx <= 20; idx++) begin
      @(negedge clk);
      if (done4) dones.push_back(idx);
      if (dones.size() > 0 && (d4 !== 4'd8 || br4 !== 1'b0)) bad++;
    end
    s4 = 1'b0;
    for (int k = 0; k < 12 && busy4; k++) @(negedge clk);
    checks++;
    if (dones.size() !== 3) begin
      errors++; $display("FAIL held_start done_count: got %0d expected 3", dones.size());
    end
    checks++;
    if (dones.size() >= 1 && dones[0] !== 5) begin
      errors++; $display("FAIL held_start first_done: got %0d expected 5", dones[0]);
    end
    for (int k = 1; k < dones.size(); k++) begin
      checks++;
      if (dones[k] - dones[k-1] !== 6) begin
        errors++; $display("FAIL held_start spacing: got %0d expected 6", dones[k] - dones[k-1]);
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL held_start diff_hold: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd1; s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (d4 !== 4'd0 || br4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got diff %0d borrow %0b busy %0b done %0b expected all 0", d4, br4, busy4, done4);
    end
    repeat (2) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL reset_mid no_done: got %0d pulses expected 0", ndone);
    end
    check_op(4, 8'd7, 8'd1, "n4_after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) check_op(4, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), "n4_rand");
  endtask

  task automatic test_n8();
    check_op(8, 8'h00, 8'h01, "n8_0m1");
    for (int i = 0; i < 6; i++) check_op(8, 8'($urandom), 8'($urandom), "n8_rand");
  endtask

  task automatic test_n1();
    check_op(1, 8'd0, 8'd1, "n1_0m1");
    for (int i = 0; i < 4; i++) check_op(1, 8'(i & 1), 8'(i >> 1), "n1_all");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_n8();
    test_n1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
